// File: rtl/operand_stage_pkg.sv
// rtl/operand_stage_pkg.sv - shared ALU function codes, occupancy states and default sizes
package operand_stage_pkg;

  localparam int N_DEFAULT = 16;
  localparam int R_DEFAULT = 8;

  typedef enum logic [2:0] {
    FUNC_MOV = 3'b000,
    FUNC_ADD = 3'b001,
    FUNC_SUB = 3'b010,
    FUNC_AND = 3'b011,
    FUNC_OR  = 3'b100,
    FUNC_NOT = 3'b101,
    FUNC_NOP = 3'b110
  } alu_func_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/operand_stage_reg_file.sv
// rtl/operand_stage_reg_file.sv - R x N register file, two combinational reads, one synchronous write
module reg_file #(
  parameter int N = 16,
  parameter int R = 8,
  parameter int A = $clog2(R)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [N-1:0] wdata,
  input  logic [A-1:0] raddr1,
  output logic [N-1:0] rdata1,
  input  logic [A-1:0] raddr2,
  output logic [N-1:0] rdata2
);

  logic [N-1:0] mem [R];

  // Reset clears every entry; otherwise a single write port updates one entry per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < R; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports see the stored value; a same-edge write is visible only on the next cycle.
  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - operand fetch with two-entry skid buffer; optional OPERAND_BYPASS_EN forwarding
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int R = R_DEFAULT,
  parameter int A = $clog2(R)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [A-1:0] rs1,
  input  logic [A-1:0] rs2,
  input  logic [N-1:0] imm,
  input  logic         use_imm,
  input  logic [2:0]   func_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] inp1,
  output logic [N-1:0] inp2,
  output logic [2:0]   func,
  input  logic         wb_en,
  input  logic [A-1:0] wb_addr,
  input  logic [N-1:0] wb_data,
  input  logic         flag_we,
  input  logic         alu_zero,
  output logic         zero_flag
);

  occ_state_t   state;
  logic [N-1:0] rd1, rd2;
  logic [N-1:0] cap1, cap2;
  logic [N-1:0] skid1, skid2;
  logic [2:0]   skid_func;
  logic         accept, consume;

  reg_file #(.N(N), .R(R), .A(A)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .rdata1 (rd1),
    .raddr2 (rs2),
    .rdata2 (rd2)
  );

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  // Operands captured on accept: register reads, immediate select, optional write-back forwarding.
  always_comb begin
    cap1 = rd1;
    cap2 = use_imm ? imm : rd2;
`ifdef OPERAND_BYPASS_EN
    if (wb_en && (wb_addr == rs1)) begin
      cap1 = wb_data;
    end
    if (!use_imm && wb_en && (wb_addr == rs2)) begin
      cap2 = wb_data;
    end
`else
`endif
  end

  // Occupancy FSM: head drives the ALU, skid absorbs one extra entry while the ALU stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      inp1      <= '0;
      inp2      <= '0;
      func      <= FUNC_MOV;
      skid1     <= '0;
      skid2     <= '0;
      skid_func <= FUNC_MOV;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            inp1      <= cap1;
            inp2      <= cap2;
            func      <= func_in;
            state     <= ST_ONE;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            inp1 <= cap1;
            inp2 <= cap2;
            func <= func_in;
          end else if (accept) begin
            skid1     <= cap1;
            skid2     <= cap2;
            skid_func <= func_in;
            state     <= ST_TWO;
            in_ready  <= 1'b0;
          end else if (consume) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (consume) begin
            inp1     <= skid1;
            inp2     <= skid2;
            func     <= skid_func;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Zero flag for branch logic: captured from the ALU only when requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_flag <= 1'b0;
    end else if (flag_we) begin
      zero_flag <= alu_zero;
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - randomized and directed self-checking bench for operand_stage
module tb_operand_stage;

`ifdef OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, use_imm, out_valid, out_ready;
  logic [2:0]  rs1, rs2, wb_addr, func_in, func;
  logic [15:0] imm, inp1, inp2, wb_data;
  logic        wb_en, flag_we, alu_zero, zero_flag;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  f;
  } entry_t;

  entry_t      q[$];
  logic [15:0] regs [8];
  logic        zf;

  operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm), .func_in(func_in),
    .out_valid(out_valid), .out_ready(out_ready), .inp1(inp1), .inp2(inp2),
    .func(func), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_we(flag_we), .alu_zero(alu_zero), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  // Apply the reference model to the current inputs, then advance one clock.
  task automatic cycle();
    entry_t e;
    bit acc, cons;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 8; i++) regs[i] = 16'h0;
      zf = 1'b0;
    end else begin
      acc  = in_valid && (q.size() < 2);
      cons = (q.size() > 0) && out_ready;
      e.a = (BYP && wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
      if (use_imm) e.b = imm;
      else e.b = (BYP && wb_en && wb_addr == rs2) ? wb_data : regs[rs2];
      e.f = func_in;
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (wb_en) regs[wb_addr] = wb_data;
      if (flag_we) zf = alu_zero;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; use_imm = 0; rs1 = 0; rs2 = 0; imm = 0; func_in = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; flag_we = 0; alu_zero = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); out_ready = 0;
    cycle(); cycle();
    rst = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if ({inp1, inp2, func} !== 35'h0) begin n_err++; $display("FAIL reset_outputs got %h/%h/%0d want 0/0/0", inp1, inp2, func); end
    n_cmp++; if (zero_flag !== 1'b0) begin n_err++; $display("FAIL reset_zero_flag got %0b want 0", zero_flag); end
  endtask

  task automatic test_basic();
    out_ready = 1;
    wb_en = 1; wb_addr = 3; wb_data = 16'h1234; cycle();
    wb_addr = 5; wb_data = 16'h00FF; cycle();
    wb_en = 0;
    in_valid = 1; rs1 = 3; rs2 = 5; use_imm = 0; func_in = 3'b001; cycle();
    in_valid = 0;
    n_cmp++; if ({out_valid, inp1, inp2, func} !== {1'b1, 16'h1234, 16'h00FF, 3'b001}) begin
      n_err++; $display("FAIL basic_add got v=%0b %h %h f=%0d want v=1 1234 00ff f=1", out_valid, inp1, inp2, func);
    end
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_imm();
    in_valid = 1; rs1 = 3; rs2 = 5; use_imm = 1; imm = 16'hBEEF; func_in = 3'b010; cycle();
    in_valid = 0; use_imm = 0;
    n_cmp++; if ({inp1, inp2, func} !== {16'h1234, 16'hBEEF, 3'b010}) begin
      n_err++; $display("FAIL imm_select got %h %h f=%0d want 1234 beef f=2", inp1, inp2, func);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    out_ready = 0; in_valid = 1; use_imm = 1; func_in = 3'b011;
    imm = 16'h1111; cycle();
    imm = 16'h2222; cycle();
    n_cmp++; if ({in_ready, out_valid, inp2} !== {1'b0, 1'b1, 16'h1111}) begin
      n_err++; $display("FAIL skid_full got rdy=%0b v=%0b %h want rdy=0 v=1 1111", in_ready, out_valid, inp2);
    end
    imm = 16'h3333; cycle();
    n_cmp++; if ({in_ready, out_valid, inp2} !== {1'b0, 1'b1, 16'h1111}) begin
      n_err++; $display("FAIL skid_hold got rdy=%0b v=%0b %h want rdy=0 v=1 1111", in_ready, out_valid, inp2);
    end
    in_valid = 0; use_imm = 0; out_ready = 1; cycle();
    n_cmp++; if ({in_ready, out_valid, inp2} !== {1'b1, 1'b1, 16'h2222}) begin
      n_err++; $display("FAIL skid_drain1 got rdy=%0b v=%0b %h want rdy=1 v=1 2222", in_ready, out_valid, inp2);
    end
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL skid_drain2 got v=%0b want 0", out_valid); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp;
    exp = BYP ? 16'hAAAA : 16'h0000;
    out_ready = 1; in_valid = 1; rs1 = 2; rs2 = 2; use_imm = 0; func_in = 3'b000;
    wb_en = 1; wb_addr = 2; wb_data = 16'hAAAA; cycle();
    wb_en = 0;
    n_cmp++; if ({inp1, inp2} !== {exp, exp}) begin n_err++; $display("FAIL bypass_same_cycle got %h %h want %h %h", inp1, inp2, exp, exp); end
    cycle();
    in_valid = 0;
    n_cmp++; if (inp1 !== 16'hAAAA) begin n_err++; $display("FAIL bypass_next_read got %h want aaaa", inp1); end
    cycle();
  endtask

  task automatic test_flag();
    flag_we = 1; alu_zero = 1; cycle();
    n_cmp++; if (zero_flag !== 1'b1) begin n_err++; $display("FAIL flag_set got %0b want 1", zero_flag); end
    flag_we = 0; alu_zero = 0; cycle();
    n_cmp++; if (zero_flag !== 1'b1) begin n_err++; $display("FAIL flag_hold got %0b want 1", zero_flag); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1; rs1 = 3; use_imm = 1; imm = 16'h5555; cycle(); cycle();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_full got %0b want 0", in_ready); end
    rst = 1; in_valid = 0; wb_en = 1; wb_addr = 3; wb_data = 16'hFFFF; flag_we = 1; alu_zero = 1; cycle();
    rst = 0; wb_en = 0; flag_we = 0; use_imm = 0;
    n_cmp++; if ({out_valid, in_ready, zero_flag} !== 3'b010) begin
      n_err++; $display("FAIL midrst_ctrl got v=%0b rdy=%0b z=%0b want v=0 rdy=1 z=0", out_valid, in_ready, zero_flag);
    end
    out_ready = 1; in_valid = 1; rs1 = 3; rs2 = 3; cycle();
    in_valid = 0;
    n_cmp++; if ({inp1, inp2} !== 32'h0) begin n_err++; $display("FAIL midrst_regclear got %h %h want 0 0", inp1, inp2); end
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      rs1 = 3'($urandom); rs2 = 3'($urandom); use_imm = $urandom_range(0, 2) == 0;
      imm = 16'($urandom); func_in = 3'($urandom_range(0, 6));
      wb_en = $urandom_range(0, 1) == 1; wb_addr = 3'($urandom); wb_data = 16'($urandom);
      flag_we = $urandom_range(0, 1) == 1; alu_zero = $urandom_range(0, 1) == 1;
      cycle();
      n_cmp++; if (out_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_out_valid it=%0d got %0b want %0b", i, out_valid, q.size() > 0); end
      n_cmp++; if (in_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_in_ready it=%0d got %0b want %0b", i, in_ready, q.size() < 2); end
      n_cmp++; if (zero_flag !== zf) begin n_err++; $display("FAIL rnd_zero_flag it=%0d got %0b want %0b", i, zero_flag, zf); end
      if (q.size() > 0) begin
        n_cmp++;
        if ({inp1, inp2, func} !== {q[0].a, q[0].b, q[0].f}) begin
          n_err++; $display("FAIL rnd_head it=%0d got %h %h %0d want %h %h %0d", i, inp1, inp2, func, q[0].a, q[0].b, q[0].f);
        end
      end
    end
    rst = 0; idle_inputs(); out_ready = 1; cycle(); cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm();
    test_back_to_back();
    test_bypass();
    test_flag();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
